// File: rtl/param_scrambler.sv
// Multi-channel scrambler: each accepted word is merged with entropy and XORed with a
// pad taken from one of NCH programmable Galois LFSRs, picked per word by a selector LFSR.
module param_scrambler #(
  parameter int NCH    = 4,
  parameter int LFSR_W = 64,
  parameter int DW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write,
  input  logic [11:0]   addr,
  input  logic [31:0]   lfsrdin,
  input  logic          pushin,
  input  logic [DW-1:0] datain,
  input  logic [31:0]   entrophy,
  input  logic          stopin,
  output logic          stopout,
  output logic          pushout,
  output logic [31:0]   dataout
);
  localparam int NW    = LFSR_W / 32;
  localparam int SEL_W = $clog2(NCH);

  logic [1:0]            ctrl_reg;
  logic [15:0]           sel_state_reg;
  logic [15:0]           sel_tap_reg;
  logic [15:0]           sel_seed_wr;
  logic                  s1_valid_reg;
  logic [31:0]           s1_comb_reg;
  logic [31:0]           s1_pad_reg;
  logic                  pushout_reg;
  logic [31:0]           dataout_reg;
  logic [NCH-1:0][31:0]  pad_low;
  logic [31:0]           combined;
  logic                  stall;
  logic                  accept;
  logic                  step;
  logic [3:0]            wr_region;
  logic [3:0]            wr_ch;
  logic [3:0]            wr_word;
  logic                  loc_ok;
  logic                  ctrl_we;
  logic                  seed_we;
  logic                  tap_we;
  logic                  sel_we;
  logic                  unused_entrophy;

  assign stall   = pushout_reg && stopin;
  assign stopout = stall && s1_valid_reg;
  assign accept  = pushin && !stopout;
  // A register write in the same cycle as a push suppresses every LFSR step.
  assign step    = accept && !write;

  assign wr_region = addr[11:8];
  assign wr_ch     = addr[7:4];
  assign wr_word   = addr[3:0];
  assign loc_ok    = (32'(wr_ch) < NCH) && (32'(wr_word) < NW);
  assign ctrl_we   = write && (wr_region == 4'h0);
  assign seed_we   = write && (wr_region == 4'h1) && loc_ok;
  assign tap_we    = write && (wr_region == 4'h2) && loc_ok;
  assign sel_we    = write && (wr_region == 4'h3);

  generate
    if (DW == 32) begin : g_full
      assign combined = datain;
    end else begin : g_mix
      assign combined = {entrophy[31:DW], datain};
    end
  endgenerate
  assign unused_entrophy = ^entrophy[DW-1:0];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [LFSR_W-1:0] state_reg;
      logic [LFSR_W-1:0] tap_reg;
      logic [LFSR_W-1:0] seed_wr;
      logic [LFSR_W-1:0] tap_wr;
      logic              ch_hit;

      assign ch_hit = (32'(wr_ch) == gi);

      // An all-zero state would lock up the LFSR, so bit0 is forced on such a load.
      always_comb begin
        seed_wr = state_reg;
        tap_wr  = tap_reg;
        for (int w = 0; w < NW; w++) begin
          if (32'(wr_word) == w) begin
            seed_wr[w*32 +: 32] = lfsrdin;
            tap_wr[w*32 +: 32]  = lfsrdin;
          end
        end
        if (seed_wr == '0) seed_wr[0] = 1'b1;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= LFSR_W'(1);
          tap_reg   <= '0;
        end else begin
          if (seed_we && ch_hit)
            state_reg <= seed_wr;
          else if (step)
            state_reg <= (state_reg >> 1) ^ (state_reg[0] ? tap_reg : '0);
          if (tap_we && ch_hit)
            tap_reg <= tap_wr;
        end
      end

      assign pad_low[gi] = state_reg[31:0];
    end
  endgenerate

  assign sel_seed_wr = (lfsrdin[15:0] == 16'h0) ? 16'h0001 : lfsrdin[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg      <= 2'b01;
      sel_state_reg <= 16'h0001;
      sel_tap_reg   <= 16'hB400;
    end else begin
      if (ctrl_we) ctrl_reg <= lfsrdin[1:0];
      if (sel_we) begin
        sel_state_reg <= sel_seed_wr;
        sel_tap_reg   <= lfsrdin[31:16];
      end else if (step) begin
        sel_state_reg <= (sel_state_reg >> 1) ^ (sel_state_reg[0] ? sel_tap_reg : 16'h0);
      end
    end
  end

  // Stage 1 captures with pre-step LFSR values; it may fill while stage 2 is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_comb_reg  <= '0;
      s1_pad_reg   <= '0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_comb_reg  <= combined;
      s1_pad_reg   <= pad_low[sel_state_reg[SEL_W-1:0]];
    end else if (!stall) begin
      s1_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pushout_reg <= 1'b0;
      dataout_reg <= '0;
    end else if (!stall) begin
      pushout_reg <= s1_valid_reg;
      if (s1_valid_reg)
        dataout_reg <= (ctrl_reg[1] || !ctrl_reg[0]) ? s1_comb_reg : (s1_comb_reg ^ s1_pad_reg);
    end
  end

  assign pushout = pushout_reg;
  assign dataout = dataout_reg;
endmodule
